// File: rtl/relogio_pkg.sv
// Shared definitions for the clock display path: digit count, active-low
// segment codes, field limits and the scan digit index type.
package relogio_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    localparam logic [4:0] MAX_HORAS   = 5'd23;
    localparam logic [5:0] MAX_MIN_SEG = 6'd59;

    // Scan position, left to right: HH MM SS
    typedef enum logic [2:0] {
        DIG_H_TENS  = 3'd0,
        DIG_H_UNITS = 3'd1,
        DIG_M_TENS  = 3'd2,
        DIG_M_UNITS = 3'd3,
        DIG_S_TENS  = 3'd4,
        DIG_S_UNITS = 3'd5
    } digit_idx_t;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/relogio_display_mux_seg7_decoder.sv
// BCD digit to active-low 7-segment code; dash overrides the digit.
// Non-decimal BCD values blank the digit.
module seg7_decoder
    import relogio_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    output logic [6:0] seg
);

    // Pure lookup, no state
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/relogio_display_mux.sv
// Six-digit multiplexed display driver for the HH MM SS clock.
// A time snapshot is taken once per scan frame so carries never tear the
// display; each digit slot ends with one blank cycle against ghosting.
// Optional macro RELOGIO_DP_BLINK_EN: decimal points after HH and MM blink
// with the seconds LSB. Without it dp is held high.
module relogio_display_mux
    import relogio_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            horas,
    input  logic [5:0]            minutos,
    input  logic [5:0]            segundos,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int              CNT_W    = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;
    logic             slot_end;
    digit_idx_t       idx;
    digit_idx_t       idx_next;

    logic [4:0] snap_h;
    logic [5:0] snap_m;
    logic [5:0] snap_s;

    logic [5:0] field_val;
    logic       field_bad;
    logic [3:0] digit_bcd;
    logic [6:0] seg_code;
    logic       dp_lit;

    assign slot_end = (cnt == CNT_LAST);

    // Prescaler: one digit slot every PRESCALE cycles
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index state register
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= DIG_H_TENS;
        end else begin
            idx <= idx_next;
        end
    end

    // Digit index next state: advance at slot end, wrap after seconds units
    always_comb begin
        idx_next = idx;
        if (slot_end) begin
            if (idx == DIG_S_UNITS) begin
                idx_next = DIG_H_TENS;
            end else begin
                idx_next = digit_idx_t'(idx + 3'd1);
            end
        end
    end

    // Snapshot the time bus at the last cycle of the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_h <= '0;
            snap_m <= '0;
            snap_s <= '0;
        end else if (slot_end && (idx == DIG_S_UNITS)) begin
            snap_h <= horas;
            snap_m <= minutos;
            snap_s <= segundos;
        end
    end

    // Select the field for the current digit, range-check it, split into BCD
    always_comb begin
        field_val = '0;
        field_bad = 1'b0;
        case (idx)
            DIG_H_TENS, DIG_H_UNITS: begin
                field_val = {1'b0, snap_h};
                field_bad = (snap_h > MAX_HORAS);
            end
            DIG_M_TENS, DIG_M_UNITS: begin
                field_val = snap_m;
                field_bad = (snap_m > MAX_MIN_SEG);
            end
            DIG_S_TENS, DIG_S_UNITS: begin
                field_val = snap_s;
                field_bad = (snap_s > MAX_MIN_SEG);
            end
            default: begin
                field_val = '0;
                field_bad = 1'b0;
            end
        endcase
        // Odd scan positions are the units digit of their field
        digit_bcd = idx[0] ? units_of(field_val) : tens_of(field_val);
    end

    seg7_decoder u_seg7_decoder (
        .bcd  (digit_bcd),
        .dash (field_bad),
        .seg  (seg_code)
    );

`ifdef RELOGIO_DP_BLINK_EN
    // Separator dots after HH and MM, lit on even seconds
    assign dp_lit = ~(((idx == DIG_H_UNITS) || (idx == DIG_M_UNITS)) && !snap_s[0]);
`else
    assign dp_lit = 1'b1;
`endif

    // Registered outputs; the last cycle of every slot is blanked
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (slot_end) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= seg_code;
            dp  <= dp_lit;
        end
    end

endmodule

// File: tb/tb_relogio_display_mux.sv
// Directed bench for relogio_display_mux with PRESCALE=4 (24-cycle frame).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_relogio_display_mux;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] horas;
    logic [5:0] minutos;
    logic [5:0] segundos;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;

    relogio_display_mux #(.PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .reset    (reset),
        .horas    (horas),
        .minutos  (minutos),
        .segundos (segundos),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        horas    = h;
        minutos  = m;
        segundos = s;
    endtask

    function automatic logic [5:0][6:0] pack6(input logic [6:0] d0, input logic [6:0] d1,
                                              input logic [6:0] d2, input logic [6:0] d3,
                                              input logic [6:0] d4, input logic [6:0] d5);
        logic [5:0][6:0] r;
        r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3; r[4] = d4; r[5] = d5;
        return r;
    endfunction

    function automatic logic dp_exp(input int slot, input logic [5:0] secs);
        logic sep_on;
        sep_on = ((slot == 1) || (slot == 3)) && !secs[0];
`ifdef RELOGIO_DP_BLINK_EN
        return !sep_on;
`else
        return sep_on | 1'b1;
`endif
    endfunction

    // Walk scan slots first..last, checking every cycle; optionally change the
    // time inputs after the first lit cycle of slot chg_slot.
    task automatic run_slots(input string name, input logic [5:0][6:0] codes,
                             input logic [5:0] secs, input int first, input int last,
                             input int chg_slot, input logic [4:0] h,
                             input logic [5:0] m, input logic [5:0] s);
        logic [5:0] an_exp;
        for (int sl = first; sl <= last; sl++) begin
            for (int c = 0; c < PRESCALE; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (c == PRESCALE - 1) begin
                    check($sformatf("%s slot%0d blank an", name, sl), an, 6'h3F);
                    check($sformatf("%s slot%0d blank seg", name, sl), seg, 7'h7F);
                    check($sformatf("%s slot%0d blank dp", name, sl), dp, 1'b1);
                end else begin
                    an_exp = ~(6'd1 << sl);
                    check($sformatf("%s slot%0d c%0d an", name, sl, c), an, an_exp);
                    check($sformatf("%s slot%0d c%0d seg", name, sl, c), seg, codes[sl]);
                    check($sformatf("%s slot%0d c%0d dp", name, sl, c), dp, dp_exp(sl, secs));
                end
                if (sl == chg_slot && c == 0) set_time(h, m, s);
            end
        end
    endtask

    initial begin
        logic [5:0][6:0] zeros;
        zeros = pack6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        // Reset held for three cycles
        reset = 1'b1;
        set_time(5'd0, 6'd0, 6'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset an", an, 6'h3F);
        check("reset seg", seg, 7'h7F);
        check("reset dp", dp, 1'b1);

        // Release; first frame shows the reset snapshot 00 00 00
        reset = 1'b0;
        set_time(5'd13, 6'd45, 6'd7);
        run_slots("f0_zeros", zeros, 6'd0, 0, 5, -1, 5'd0, 6'd0, 6'd0);

        run_slots("f1_134507", pack6(7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78),
                  6'd7, 0, 5, 1, 5'd24, 6'd60, 6'd59);

        run_slots("f2_range", pack6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h12, 7'h10),
                  6'd59, 0, 5, 1, 5'd10, 6'd0, 6'd0);

        // Inputs change mid-frame at idx2; this frame must stay 10:00:00
        run_slots("f3_100000", pack6(7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40),
                  6'd0, 0, 5, 2, 5'd11, 6'd11, 6'd11);

        run_slots("f4_111111", pack6(7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79),
                  6'd11, 0, 2, -1, 5'd0, 6'd0, 6'd0);

        // First lit cycle of idx3, then reset pulsed for one edge
        @(posedge clk);
        @(negedge clk);
        check("f4 slot3 an", an, 6'h37);
        check("f4 slot3 seg", seg, 7'h79);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset an", an, 6'h3F);
        check("midreset seg", seg, 7'h7F);
        check("midreset dp", dp, 1'b1);
        reset = 1'b0;
        set_time(5'd12, 6'd34, 6'd8);

        run_slots("f5_after_reset", zeros, 6'd0, 0, 5, -1, 5'd0, 6'd0, 6'd0);

        run_slots("f6_123408", pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h00),
                  6'd8, 0, 5, 1, 5'd12, 6'd34, 6'd9);

        run_slots("f7_123409", pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h40, 7'h10),
                  6'd9, 0, 5, -1, 5'd0, 6'd0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
